// File: rtl/pc_fetch_seq.sv
// Fetch-address sequencer: BOOT -> RUN -> HALT, with one prioritized pending-redirect slot.
// A redirect that arrives while a request waits for fetch_ready is held until the next handshake (or stall cycle).
module pc_fetch_seq #(
  parameter int unsigned    N            = 32,
  parameter logic [N-1:0]   RESET_VECTOR = '0,
  parameter logic [N-1:0]   EXC_VECTOR   = N'(32'h0000_0180),
  parameter int unsigned    INC          = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         halt,
  input  logic         exception,
  input  logic         jump,
  input  logic [N-1:0] jump_target,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         fetch_ready,
  output logic         fetch_valid,
  output logic [N-1:0] pc,
  output logic [N-1:0] pc_plus_inc,
  output logic         misalign_err,
  output logic         halted
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_HALT} state_t;

  localparam logic [N-1:0] INC_V = N'(INC);

  state_t       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic         pend_vld_q, pend_vld_d;
  logic [1:0]   pend_rank_q, pend_rank_d;
  logic [N-1:0] pend_tgt_q, pend_tgt_d;

  // Rank of this cycle's redirect input: 3 exception, 2 jump, 1 branch, 0 none.
  logic [1:0]   in_rank;
  logic [N-1:0] in_tgt;
  logic         in_mis;
  logic         hs;

  assign pc          = pc_q;
  assign pc_plus_inc = pc_q + INC_V;

  always_comb begin
    in_rank = 2'd0;
    in_tgt  = pc_q;
    in_mis  = 1'b0;
    if (exception) begin
      in_rank = 2'd3;
      in_tgt  = EXC_VECTOR;
    end else if (jump) begin
      in_rank = 2'd2;
      in_mis  = |jump_target[1:0];
      in_tgt  = in_mis ? EXC_VECTOR : jump_target;
    end else if (branch_taken) begin
      in_rank = 2'd1;
      in_mis  = |branch_target[1:0];
      in_tgt  = in_mis ? EXC_VECTOR : branch_target;
    end
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_vld_d   = pend_vld_q;
    pend_rank_d  = pend_rank_q;
    pend_tgt_d   = pend_tgt_q;
    fetch_valid  = 1'b0;
    halted       = 1'b0;
    misalign_err = 1'b0;
    hs           = 1'b0;

    case (state_q)
      S_BOOT: begin
        pc_d       = RESET_VECTOR;
        pend_vld_d = 1'b0;
        state_d    = S_RUN;
      end

      S_RUN: begin
        fetch_valid = ~stall;
        hs          = ~stall & fetch_ready;
        // A stalled cycle has no request outstanding, so redirects may land at once.
        if (hs || stall) begin
          pend_vld_d   = 1'b0;
          misalign_err = in_mis;
          if (in_rank != 2'd0) begin
            pc_d = in_tgt;
          end else if (pend_vld_q) begin
            pc_d = pend_tgt_q;
          end else if (hs) begin
            pc_d = pc_plus_inc;
          end
        end else if ((in_rank != 2'd0) && (!pend_vld_q || (in_rank >= pend_rank_q))) begin
          pend_vld_d   = 1'b1;
          pend_rank_d  = in_rank;
          pend_tgt_d   = in_tgt;
          misalign_err = in_mis;
        end
        if (halt && !exception) begin
          state_d = S_HALT;
        end
      end

      S_HALT: begin
        halted     = 1'b1;
        pend_vld_d = 1'b0;
        if (exception) begin
          pc_d    = EXC_VECTOR;
          state_d = S_RUN;
        end
      end

      default: begin
        state_d = S_BOOT;
      end
    endcase

    if (reset) begin
      misalign_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_VECTOR;
      pend_vld_q  <= 1'b0;
      pend_rank_q <= 2'd0;
      pend_tgt_q  <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      pend_vld_q  <= pend_vld_d;
      pend_rank_q <= pend_rank_d;
      pend_tgt_q  <= pend_tgt_d;
    end
  end

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Bench for pc_fetch_seq: directed scenarios plus random traffic against a rule-level model (32-bit),
// and a wrap/reset scenario on an 8-bit instance.
module tb_pc_fetch_seq;

  localparam logic [31:0] EXC = 32'h0000_0180;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, stall, halt, exception, jump, branch_taken, fetch_ready;
  logic [31:0] jump_target, branch_target;
  logic        fetch_valid, misalign_err, halted;
  logic [31:0] pc, pc_plus_inc;

  logic        r8, s8, h8, e8, j8, b8, fr8;
  logic [7:0]  jt8, bt8;
  logic        fv8, me8, hd8;
  logic [7:0]  pc8, ppi8;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Model state: mode -1 unknown, 0 boot, 1 run, 2 halt.
  int          m_mode = -1;
  logic [31:0] m_pc   = '0;
  logic        m_pv   = 1'b0;
  int          m_pr   = 0;
  logic [31:0] m_pt   = '0;

  pc_fetch_seq dut (
    .clk(clk), .reset(reset), .stall(stall), .halt(halt), .exception(exception),
    .jump(jump), .jump_target(jump_target), .branch_taken(branch_taken),
    .branch_target(branch_target), .fetch_ready(fetch_ready), .fetch_valid(fetch_valid),
    .pc(pc), .pc_plus_inc(pc_plus_inc), .misalign_err(misalign_err), .halted(halted)
  );

  pc_fetch_seq #(.N(8), .RESET_VECTOR(8'hF8)) dut8 (
    .clk(clk), .reset(r8), .stall(s8), .halt(h8), .exception(e8),
    .jump(j8), .jump_target(jt8), .branch_taken(b8),
    .branch_target(bt8), .fetch_ready(fr8), .fetch_valid(fv8),
    .pc(pc8), .pc_plus_inc(ppi8), .misalign_err(me8), .halted(hd8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_tgt();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 3) == 0) t[1:0] = 2'($urandom_range(1, 3));
    return t;
  endfunction

  // Check outputs of the 32-bit DUT against the model for the current cycle, then advance one clock.
  task automatic step();
    logic        e_fv, e_mis, raw_mis, hs;
    int          rank, n_mode, n_pr;
    logic [31:0] tgt, n_pc, n_pt;
    logic        n_pv;
    #1;
    e_fv    = (m_mode == 1) && !stall;
    rank    = exception ? 3 : jump ? 2 : branch_taken ? 1 : 0;
    raw_mis = (rank == 2 && jump_target[1:0] != 2'b00) || (rank == 1 && branch_target[1:0] != 2'b00);
    tgt     = (rank == 3 || raw_mis) ? EXC : (rank == 2) ? jump_target : branch_target;
    hs      = e_fv && fetch_ready;
    e_mis   = 1'b0;
    n_mode  = m_mode; n_pc = m_pc; n_pv = m_pv; n_pr = m_pr; n_pt = m_pt;
    if (reset) begin
      n_mode = 0; n_pc = 32'h0; n_pv = 1'b0;
    end else if (m_mode == 0) begin
      n_mode = 1; n_pc = 32'h0; n_pv = 1'b0;
    end else if (m_mode == 1) begin
      if (hs || stall) begin
        if (rank > 0) begin
          n_pc  = tgt;
          e_mis = raw_mis;
        end else if (m_pv) begin
          n_pc = m_pt;
        end else if (hs) begin
          n_pc = m_pc + 32'd4;
        end
        n_pv = 1'b0;
      end else if (rank > 0 && (!m_pv || rank >= m_pr)) begin
        n_pv = 1'b1; n_pr = rank; n_pt = tgt;
        e_mis = raw_mis;
      end
      n_mode = (halt && !exception) ? 2 : 1;
    end else if (m_mode == 2) begin
      n_pv = 1'b0;
      if (exception) begin
        n_pc = EXC; n_mode = 1;
      end
    end
    if (m_mode >= 0) begin
      check("m_fetch_valid", 32'(fetch_valid), 32'(e_fv));
      check("m_pc", pc, m_pc);
      check("m_pc_plus_inc", pc_plus_inc, m_pc + 32'd4);
      check("m_halted", 32'(halted), 32'(m_mode == 2));
      check("m_misalign", 32'(misalign_err), 32'(e_mis));
    end
    m_mode = n_mode; m_pc = n_pc; m_pv = n_pv; m_pr = n_pr; m_pt = n_pt;
    @(posedge clk);
    #1;
  endtask

  task automatic tick8();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; halt = 1'b0; exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    fetch_ready = 1'b1; jump_target = '0; branch_target = '0;
    r8 = 1'b1; s8 = 1'b0; h8 = 1'b0; e8 = 1'b0; j8 = 1'b0; b8 = 1'b0; fr8 = 1'b1; jt8 = '0; bt8 = '0;
    @(posedge clk);
    #1;

    // Reset release and sequential fetch.
    step(); step();
    reset = 1'b0;
    #1;
    check("boot_fetch_valid", 32'(fetch_valid), 32'd0);
    check("boot_pc", pc, 32'h0);
    check("boot_halted", 32'(halted), 32'd0);
    check("boot_misalign", 32'(misalign_err), 32'd0);
    step();
    check("first_fetch_valid", 32'(fetch_valid), 32'd1);
    check("first_pc", pc, 32'h0);
    step(); check("seq_pc_4", pc, 32'h4);
    step(); check("seq_pc_8", pc, 32'h8);
    step(); check("seq_pc_c", pc, 32'hC);
    step(); check("seq_pc_10", pc, 32'h10);

    // Branch while fetch_ready is low is held pending.
    fetch_ready = 1'b0; branch_taken = 1'b1; branch_target = 32'h40;
    step();
    branch_taken = 1'b0;
    check("wait_pc_hold", pc, 32'h10);
    check("wait_fetch_valid", 32'(fetch_valid), 32'd1);
    step();
    check("wait_pc_hold2", pc, 32'h10);
    fetch_ready = 1'b1;
    step();
    check("pending_branch_pc", pc, 32'h40);

    // Priority: exception beats jump and branch.
    exception = 1'b1; jump = 1'b1; jump_target = 32'h200; branch_taken = 1'b1; branch_target = 32'h300;
    step();
    exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    check("prio_exc_pc", pc, 32'h180);
    check("prio_pc_plus_inc", pc_plus_inc, 32'h184);

    // Misaligned jump target.
    jump = 1'b1; jump_target = 32'h102;
    #1;
    check("misalign_pulse", 32'(misalign_err), 32'd1);
    step();
    jump = 1'b0;
    #1;
    check("misalign_pc", pc, 32'h180);
    check("misalign_cleared", 32'(misalign_err), 32'd0);

    // Halt, ignored jump, exception exit.
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_halted", 32'(halted), 32'd1);
    check("halt_fetch_valid", 32'(fetch_valid), 32'd0);
    check("halt_pc", pc, 32'h184);
    jump = 1'b1; jump_target = 32'h500;
    step();
    jump = 1'b0;
    check("halt_jump_ignored", pc, 32'h184);
    exception = 1'b1;
    step();
    exception = 1'b0;
    check("halt_exit_pc", pc, 32'h180);
    check("halt_exit_halted", 32'(halted), 32'd0);
    check("halt_exit_fetch_valid", 32'(fetch_valid), 32'd1);

    // Redirect during stall lands without a handshake.
    stall = 1'b1; jump = 1'b1; jump_target = 32'h600;
    #1;
    check("stall_fetch_valid", 32'(fetch_valid), 32'd0);
    step();
    stall = 1'b0; jump = 1'b0;
    check("stall_jump_pc", pc, 32'h600);

    // Simultaneous halt and exception stays in RUN.
    halt = 1'b1; exception = 1'b1;
    step();
    halt = 1'b0; exception = 1'b0;
    check("halt_exc_halted", 32'(halted), 32'd0);
    check("halt_exc_pc", pc, 32'h180);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset         = ($urandom_range(0, 59) == 0);
      stall         = ($urandom_range(0, 3) == 0);
      fetch_ready   = ($urandom_range(0, 2) != 0);
      halt          = ($urandom_range(0, 24) == 0);
      exception     = ($urandom_range(0, 19) == 0);
      jump          = ($urandom_range(0, 6) == 0);
      branch_taken  = ($urandom_range(0, 5) == 0);
      jump_target   = rand_tgt();
      branch_target = rand_tgt();
      step();
    end
    reset = 1'b0; stall = 1'b0; halt = 1'b0; exception = 1'b0; jump = 1'b0; branch_taken = 1'b0;

    // 8-bit instance: wrap-around, then reset during stall with a pending redirect.
    r8 = 1'b0;
    #1;
    check("w8_boot_fetch_valid", 32'(fv8), 32'd0);
    check("w8_boot_pc", 32'(pc8), 32'hF8);
    tick8();
    check("w8_first_fetch_valid", 32'(fv8), 32'd1);
    check("w8_pc_f8", 32'(pc8), 32'hF8);
    tick8();
    check("w8_pc_fc", 32'(pc8), 32'hFC);
    check("w8_pc_plus_inc_wrap", 32'(ppi8), 32'h00);
    tick8();
    check("w8_pc_00", 32'(pc8), 32'h00);
    fr8 = 1'b0; j8 = 1'b1; jt8 = 8'h20;
    tick8();
    j8 = 1'b0;
    check("w8_pending_hold", 32'(pc8), 32'h00);
    s8 = 1'b1; r8 = 1'b1;
    tick8();
    r8 = 1'b0; s8 = 1'b0; fr8 = 1'b1;
    #1;
    check("w8_reset_pc", 32'(pc8), 32'hF8);
    check("w8_reset_fetch_valid", 32'(fv8), 32'd0);
    tick8();
    check("w8_rerun_pc", 32'(pc8), 32'hF8);
    check("w8_rerun_fetch_valid", 32'(fv8), 32'd1);
    tick8();
    check("w8_pending_discarded", 32'(pc8), 32'hFC);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pc_fetch_seq.md
PC_FETCH_SEQ -- requirements
Module: pc_fetch_seq

Interface
REQ-001 SHALL have parameter N, default 32: PC/address width in bits.
REQ-002 SHALL have parameter RESET_VECTOR, default 0: first fetch address after reset.
REQ-003 SHALL have parameter EXC_VECTOR, default 32'h0000_0180: exception and misalignment handler address.
REQ-004 SHALL have parameter INC, default 4: sequential PC step in bytes.
REQ-005 SHALL use one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-006 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- stall  in  1  pipeline hold; blocks new fetch launch and sequential advance
- halt  in  1  enter HALT state
- exception  in  1  trap request, redirect to EXC_VECTOR
- jump  in  1  jump redirect request
- jump_target  in  N  jump address
- branch_taken  in  1  branch redirect request
- branch_target  in  N  branch address
- fetch_ready  in  1  instruction memory accepts request
- fetch_valid  out  1  fetch request valid
- pc  out  N  current fetch address
- pc_plus_inc  out  N  pc + INC, combinational, modulo 2^N
- misalign_err  out  1  one-cycle pulse on misaligned redirect target
- halted  out  1  high while in HALT

Function
REQ-007 SHALL implement states BOOT, RUN, HALT.
REQ-008 In BOOT, fetch_valid SHALL be 0 and pc SHALL be RESET_VECTOR; the next cycle SHALL be RUN unconditionally.
REQ-009 In RUN, fetch_valid SHALL equal ~stall.
REQ-010 A handshake SHALL occur when fetch_valid & fetch_ready are both 1.
REQ-011 While fetch_valid=1 and fetch_ready=0, pc SHALL hold stable.
REQ-012 Redirect priority SHALL be exception > jump > branch_taken > sequential.
REQ-013 Redirect inputs SHALL be sampled every cycle, in every state except BOOT.
REQ-014 On a handshake with no pending redirect and no redirect input, pc SHALL become pc+INC one cycle later, wrapping modulo 2^N.
REQ-015 A redirect input in a cycle without a handshake SHALL be stored in a single pending-redirect register, with pc unchanged.
REQ-016 A later higher- or equal-priority redirect SHALL overwrite the stored target; a lower-priority one SHALL be ignored.
REQ-017 On a handshake, the next pc SHALL be, in priority order: a same-cycle redirect input, else the pending target, else pc+INC.
REQ-018 The pending register SHALL clear on that handshake.
REQ-019 While stall=1 (fetch_valid=0), pending redirects SHALL apply on the next cycle without waiting for a handshake.
REQ-020 A jump or branch target with target[1:0]!=0 SHALL be replaced by EXC_VECTOR.
REQ-021 For such a target, misalign_err SHALL pulse for exactly one cycle, the cycle the redirect is sampled.
REQ-022 halt=1 in RUN SHALL enter HALT the next cycle, after any in-flight handshake completes in the current cycle.
REQ-023 In HALT, fetch_valid SHALL be 0 and halted SHALL be 1; pc SHALL hold.
REQ-024 HALT SHALL exit only on exception: pc becomes EXC_VECTOR and the state becomes RUN on the next cycle.
REQ-025 HALT SHALL ignore jump and branch_taken.
REQ-026 A simultaneous halt and exception in RUN SHALL take the exception; the state stays RUN.

Reset
REQ-027 reset=1 at a rising edge SHALL set state=BOOT, pc=RESET_VECTOR, fetch_valid=0, misalign_err=0, halted=0, and clear the pending register.
REQ-028 Reset SHALL take precedence over all other inputs, including a mid-handshake or pending redirect.
REQ-029 After reset deasserts, the first fetch_valid=1 SHALL appear in the second cycle, with pc=RESET_VECTOR.

Verification
REQ-030 Reset release with fetch_ready=1 and no redirects -> fetch_valid rises in cycle 2; pc sequence 0x0, 0x4, 0x8, 0xC on consecutive cycles.
REQ-031 Hold fetch_ready=0 at pc=0x10 and pulse branch_taken with target 0x40 -> pc stays 0x10 until ready=1; the next pc is 0x40, not 0x14.
REQ-032 Same cycle: exception=1, jump=1 to 0x200, branch to 0x300 -> next pc = 0x180.
REQ-033 Jump to 0x102 -> next pc = 0x180; misalign_err high for one cycle.
REQ-034 halt in RUN -> halted=1 and fetch_valid=0; jump to 0x500 ignored; exception -> pc=0x180, RUN, fetch_valid=1.
REQ-035 Wrap-around with N=8, RESET_VECTOR=8'hF8 -> pc sequence F8, FC, 00; then reset asserted mid-stall with a pending redirect -> pc=F8, pending redirect discarded.
